id_ex_stage: RTL and testbench
==============================

# id_ex_stage
ID/EX pipeline stage directly upstream of the EX-stage ALU in the 5-stage RV32 core. Registers decoded operands and control from ID, decodes the 3-bit ALU control code, and applies EX/MEM and MEM/WB forwarding to the ALU operands. Detects load-use hazards and inserts a bubble; the hazard flag also stalls PC and IF/ID.
## Interface
- XLEN, 32, datapath width
- clk_i  in  1  clock, all state updates on rising edge
- rst_i  in  1  synchronous, active-high reset
- stall_i  in  1  global hold (e.g. memory wait); ID/EX register keeps its value
- flush_i  in  1  insert bubble into ID/EX (taken branch resolved in ID)
- RS1data_i / RS2data_i  in  XLEN  register-file read data from ID
- imm_i  in  XLEN  sign-extended immediate from ID
- RS1addr_i / RS2addr_i / RDaddr_i  in  5  source and destination register numbers
- ctrl_i  in  7  {RegWrite, MemtoReg, MemRead, MemWrite, ALUSrc, ALUOp[1:0]}
- funct_i  in  10  {funct7, funct3}
- EXMEM_RegWrite_i  in  1 ; EXMEM_RDaddr_i  in  5 ; EXMEM_data_i  in  XLEN  EX/MEM forwarding source
- MEMWB_RegWrite_i  in  1 ; MEMWB_RDaddr_i  in  5 ; MEMWB_data_i  in  XLEN  MEM/WB forwarding source (post write-back mux)
- data1_o  out  XLEN  ALU operand 1 (forwarded rs1)
- data2_o  out  XLEN  ALU operand 2 (imm if ALUSrc, else forwarded rs2)
- ALUCtrl_o  out  3  registered ALU control code
- store_data_o  out  XLEN  forwarded rs2, to EX/MEM for stores
- RDaddr_o  out  5  registered rd
- ctrl_o  out  4  registered {RegWrite, MemtoReg, MemRead, MemWrite}
- hazard_o  out  1  load-use hazard; combinational
## Operation
- ALU codes: AND 000, XOR 001, SLL 010, ADD 011, SUB 100, MUL 101, ADDI 110, SRAI 111.
- ALUOp 00 (load/store) -> ADD. ALUOp 10 (R-type): funct 0000000_111 AND, 0000000_100 XOR, 0000000_001 SLL, 0000000_000 ADD, 0100000_000 SUB, 0000001_000 MUL. ALUOp 11 (I-type): funct3 000 ADDI, funct3 101 SRAI (funct7 ignored; shamt carried in imm). Any other combination -> ADD.
- ALU code decoded from ID inputs and captured in the ID/EX register alongside operands.
- hazard_o = MemRead_q && RDaddr_q != 0 && (RDaddr_q == RS1addr_i || RDaddr_q == RS2addr_i).
- Register update priority per edge: rst_i -> all fields zero; else stall_i -> hold; else flush_i or hazard_o -> bubble (all control bits, rd, rs addresses, ALU code zero; data fields zero); else load ID inputs.
- Forward select per source (rs1_q, rs2_q): EX/MEM if EXMEM_RegWrite_i && EXMEM_RDaddr_i != 0 && match; else MEM/WB if MEMWB_RegWrite_i && MEMWB_RDaddr_i != 0 && match; else registered RF data. EX/MEM wins when both match.
- x0 never forwarded; rs == 0 always yields registered data (zero from RF).
## Timing
- ID -> EX latency: one cycle. Forwarding muxes and data2 select are combinational on registered state plus forwarding inputs.
- Reset values: ctrl_o 0, RDaddr_o 0, ALUCtrl_o 000, data1_o 0, data2_o 0, store_data_o 0 (holds while forwarding inputs carry no matching non-zero rd).
- stall_i with hazard_o high: hold wins; hazard_o stays high, bubble inserted on the first non-stalled edge.
- Load-use bubble lasts exactly one cycle; next cycle the dependent instruction is forwarded from MEM/WB.
## Structure
- cpu_pkg: ALU control codes, ALUOp encodings, forward-select encodings (00 RF, 10 EX/MEM, 01 MEM/WB), control-bundle bit positions.
- Sub-module alu_control: combinational {ALUOp, funct} -> ALU code decoder, reused by any future EX-stage variant.
## Test plan
- R-type sub x3,x1,x2 with RS1data 10, RS2data 3, funct 0100000_000 -> next cycle ALUCtrl_o 100, data1_o 10, data2_o 3.
- srai with ALUOp 11, funct3 101, imm 4 -> ALUCtrl_o 111, data2_o 4; unknown funct under ALUOp 10 -> 011.
- Back-to-back add x5 then use x5 as rs1, EXMEM_data_i 0x55 and MEMWB_data_i 0x66 both matching rd 5 -> data1_o 0x55.
- Load to x7 registered, ID presents rs2 = 7 -> hazard_o 1; next cycle ctrl_o 0, RDaddr_o 0; following cycle forwarded from MEM/WB.
- Forwarding inputs targeting rd 0 with rs1 0 -> data1_o 0; rst_i pulsed mid-stream -> all outputs 0 next edge; stall_i holds ALUCtrl_o and data across 3 cycles.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared encodings for the RV32 pipeline: ALU codes, ALUOp classes, forwarding
// selects and control-bundle bit positions.
package cpu_pkg;

  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    ALU_AND  = 3'b000,
    ALU_XOR  = 3'b001,
    ALU_SLL  = 3'b010,
    ALU_ADD  = 3'b011,
    ALU_SUB  = 3'b100,
    ALU_MUL  = 3'b101,
    ALU_ADDI = 3'b110,
    ALU_SRAI = 3'b111
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    ALUOP_MEM    = 2'b00,
    ALUOP_BRANCH = 2'b01,
    ALUOP_R      = 2'b10,
    ALUOP_I      = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_MEMWB = 2'b01,
    FWD_EXMEM = 2'b10
  } fwd_sel_e;

  // Positions within ctrl_i = {RegWrite, MemtoReg, MemRead, MemWrite, ALUSrc, ALUOp[1:0]}
  localparam int CTRL_REGWRITE = 6;
  localparam int CTRL_ALUSRC   = 2;
  localparam int CTRL_ALUOP_HI = 1;

  // Positions within the registered bundle {RegWrite, MemtoReg, MemRead, MemWrite, ALUSrc}
  localparam int EXC_MEMREAD = 2;
  localparam int EXC_ALUSRC  = 0;

  typedef struct packed {
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1_addr;
    logic [4:0]      rs2_addr;
    logic [4:0]      rd_addr;
    logic [4:0]      ctrl;
    logic [2:0]      alu_ctrl;
  } id_ex_t;

  // EX/MEM has priority; x0 is never a forwarding target.
  function automatic fwd_sel_e fwd_select(input logic [4:0] rs,
                                          input logic       exmem_rw,
                                          input logic [4:0] exmem_rd,
                                          input logic       memwb_rw,
                                          input logic [4:0] memwb_rd);
    if (exmem_rw && exmem_rd != 5'd0 && exmem_rd == rs)
      return FWD_EXMEM;
    else if (memwb_rw && memwb_rd != 5'd0 && memwb_rd == rs)
      return FWD_MEMWB;
    else
      return FWD_RF;
  endfunction

endpackage

// File: rtl/alu_control.sv
// Combinational {ALUOp, funct7, funct3} -> 3-bit ALU control decoder.
module alu_control
  import cpu_pkg::*;
(
  input  logic [1:0] alu_op_i,
  input  logic [9:0] funct_i,
  output logic [2:0] alu_ctrl_o
);

  always_comb begin
    alu_ctrl_o = ALU_ADD;
    case (alu_op_i)
      ALUOP_R: begin
        case (funct_i)
          10'b0000000_111: alu_ctrl_o = ALU_AND;
          10'b0000000_100: alu_ctrl_o = ALU_XOR;
          10'b0000000_001: alu_ctrl_o = ALU_SLL;
          10'b0000000_000: alu_ctrl_o = ALU_ADD;
          10'b0100000_000: alu_ctrl_o = ALU_SUB;
          10'b0000001_000: alu_ctrl_o = ALU_MUL;
          default:         alu_ctrl_o = ALU_ADD;
        endcase
      end
      // I-type: funct7 is don't-care, the shift amount travels in the immediate
      ALUOP_I: begin
        case (funct_i[2:0])
          3'b000:  alu_ctrl_o = ALU_ADDI;
          3'b101:  alu_ctrl_o = ALU_SRAI;
          default: alu_ctrl_o = ALU_ADD;
        endcase
      end
      default: alu_ctrl_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with ALU-control decode, EX/MEM and MEM/WB operand
// forwarding, and load-use hazard detection (bubble insertion).
module id_ex_stage
  import cpu_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            stall_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] RS1data_i,
  input  logic [XLEN-1:0] RS2data_i,
  input  logic [XLEN-1:0] imm_i,
  input  logic [4:0]      RS1addr_i,
  input  logic [4:0]      RS2addr_i,
  input  logic [4:0]      RDaddr_i,
  input  logic [6:0]      ctrl_i,
  input  logic [9:0]      funct_i,
  input  logic            EXMEM_RegWrite_i,
  input  logic [4:0]      EXMEM_RDaddr_i,
  input  logic [XLEN-1:0] EXMEM_data_i,
  input  logic            MEMWB_RegWrite_i,
  input  logic [4:0]      MEMWB_RDaddr_i,
  input  logic [XLEN-1:0] MEMWB_data_i,
  output logic [XLEN-1:0] data1_o,
  output logic [XLEN-1:0] data2_o,
  output logic [2:0]      ALUCtrl_o,
  output logic [XLEN-1:0] store_data_o,
  output logic [4:0]      RDaddr_o,
  output logic [3:0]      ctrl_o,
  output logic            hazard_o
);

  id_ex_t     idex_q, idex_d;
  logic [2:0] alu_ctrl_dec;
  fwd_sel_e   fwd_a, fwd_b;
  logic [XLEN-1:0] rs2_fwd;

  alu_control u_alu_control (
    .alu_op_i   (ctrl_i[CTRL_ALUOP_HI -: 2]),
    .funct_i    (funct_i),
    .alu_ctrl_o (alu_ctrl_dec)
  );

  assign hazard_o = idex_q.ctrl[EXC_MEMREAD] && (idex_q.rd_addr != 5'd0) &&
                    ((idex_q.rd_addr == RS1addr_i) || (idex_q.rd_addr == RS2addr_i));

  // Stall outranks the bubble so a pending load-use hazard survives a memory wait.
  always_comb begin
    idex_d = idex_q;
    if (!stall_i) begin
      if (flush_i || hazard_o) begin
        idex_d = '0;
      end else begin
        idex_d.rs1_data = RS1data_i;
        idex_d.rs2_data = RS2data_i;
        idex_d.imm      = imm_i;
        idex_d.rs1_addr = RS1addr_i;
        idex_d.rs2_addr = RS2addr_i;
        idex_d.rd_addr  = RDaddr_i;
        idex_d.ctrl     = ctrl_i[CTRL_REGWRITE:CTRL_ALUSRC];
        idex_d.alu_ctrl = alu_ctrl_dec;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) idex_q <= '0;
    else       idex_q <= idex_d;
  end

  always_comb begin
    fwd_a = fwd_select(idex_q.rs1_addr, EXMEM_RegWrite_i, EXMEM_RDaddr_i,
                       MEMWB_RegWrite_i, MEMWB_RDaddr_i);
    fwd_b = fwd_select(idex_q.rs2_addr, EXMEM_RegWrite_i, EXMEM_RDaddr_i,
                       MEMWB_RegWrite_i, MEMWB_RDaddr_i);

    case (fwd_a)
      FWD_EXMEM: data1_o = EXMEM_data_i;
      FWD_MEMWB: data1_o = MEMWB_data_i;
      default:   data1_o = idex_q.rs1_data;
    endcase

    case (fwd_b)
      FWD_EXMEM: rs2_fwd = EXMEM_data_i;
      FWD_MEMWB: rs2_fwd = MEMWB_data_i;
      default:   rs2_fwd = idex_q.rs2_data;
    endcase
  end

  assign data2_o      = idex_q.ctrl[EXC_ALUSRC] ? idex_q.imm : rs2_fwd;
  assign store_data_o = rs2_fwd;
  assign ALUCtrl_o    = idex_q.alu_ctrl;
  assign RDaddr_o     = idex_q.rd_addr;
  assign ctrl_o       = idex_q.ctrl[4:1];

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed-vector bench for id_ex_stage: decode, forwarding, load-use bubble,
// stall/flush/reset behaviour, all against hand-computed expectations.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst, stall, flush;
  logic [31:0] rs1d, rs2d, imm;
  logic [4:0]  rs1a, rs2a, rda;
  logic [6:0]  ctrl;
  logic [9:0]  funct;
  logic        exmem_rw, memwb_rw;
  logic [4:0]  exmem_rd, memwb_rd;
  logic [31:0] exmem_data, memwb_data;
  logic [31:0] data1, data2, store_data;
  logic [2:0]  aluctrl;
  logic [4:0]  rd_out;
  logic [3:0]  ctrl_out;
  logic        hazard;

  int checks   = 0;
  int failures = 0;

  // ctrl_i patterns: {RegWrite, MemtoReg, MemRead, MemWrite, ALUSrc, ALUOp}
  localparam logic [6:0] C_RTYPE = 7'b1000010;
  localparam logic [6:0] C_ITYPE = 7'b1000111;
  localparam logic [6:0] C_LOAD  = 7'b1110100;
  localparam logic [9:0] F_SUB   = 10'b0100000_000;
  localparam logic [9:0] F_ADD   = 10'b0000000_000;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk_i(clk), .rst_i(rst), .stall_i(stall), .flush_i(flush),
    .RS1data_i(rs1d), .RS2data_i(rs2d), .imm_i(imm),
    .RS1addr_i(rs1a), .RS2addr_i(rs2a), .RDaddr_i(rda),
    .ctrl_i(ctrl), .funct_i(funct),
    .EXMEM_RegWrite_i(exmem_rw), .EXMEM_RDaddr_i(exmem_rd), .EXMEM_data_i(exmem_data),
    .MEMWB_RegWrite_i(memwb_rw), .MEMWB_RDaddr_i(memwb_rd), .MEMWB_data_i(memwb_data),
    .data1_o(data1), .data2_o(data2), .ALUCtrl_o(aluctrl),
    .store_data_o(store_data), .RDaddr_o(rd_out), .ctrl_o(ctrl_out),
    .hazard_o(hazard)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, obs, exp);
    end else begin
      $display("ok   %s got=%h", tag, obs);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] im,
                        input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] rd,
                        input logic [6:0] c, input logic [9:0] f);
    rs1d = d1; rs2d = d2; imm = im;
    rs1a = a1; rs2a = a2; rda = rd;
    ctrl = c;  funct = f;
  endtask

  task automatic fwd_off();
    exmem_rw = 1'b0; exmem_rd = 5'd0; exmem_data = 32'h0;
    memwb_rw = 1'b0; memwb_rd = 5'd0; memwb_data = 32'h0;
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, "_data1"}, data1, 32'h0);
    check({pfx, "_data2"}, data2, 32'h0);
    check({pfx, "_store"}, store_data, 32'h0);
    check({pfx, "_alu"}, {29'h0, aluctrl}, 32'h0);
    check({pfx, "_rd"}, {27'h0, rd_out}, 32'h0);
    check({pfx, "_ctrl"}, {28'h0, ctrl_out}, 32'h0);
  endtask

  // ALU decode table: {ALUOp, funct} -> expected code
  logic [1:0] tab_op  [12] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10,
                               2'b10, 2'b11, 2'b11, 2'b11, 2'b00, 2'b01};
  logic [9:0] tab_fn  [12] = '{10'b0000000_111, 10'b0000000_100, 10'b0000000_001,
                               10'b0000000_000, 10'b0000001_000, 10'b0000000_110,
                               10'b0100000_111, 10'b0000000_000, 10'b0100000_101,
                               10'b0000000_010, 10'b0100000_000, 10'b0000000_111};
  logic [2:0] tab_exp [12] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b101, 3'b011,
                               3'b011, 3'b110, 3'b111, 3'b011, 3'b011, 3'b011};

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    set_id(32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 7'h0, 10'h0);
    fwd_off();
    step(); step();
    rst = 1'b0;
    check_all_zero("reset");
    check("reset_hazard", {31'h0, hazard}, 32'h0);

    // sub x3, x1, x2
    set_id(32'd10, 32'd3, 32'h0, 5'd1, 5'd2, 5'd3, C_RTYPE, F_SUB);
    step();
    check("sub_alu", {29'h0, aluctrl}, 32'h4);
    check("sub_data1", data1, 32'd10);
    check("sub_data2", data2, 32'd3);
    check("sub_rd", {27'h0, rd_out}, 32'd3);
    check("sub_ctrl", {28'h0, ctrl_out}, 32'h8);

    // srai: funct7 set but ignored, shamt in imm
    set_id(32'h80, 32'h5, 32'd4, 5'd1, 5'd0, 5'd4, C_ITYPE, 10'b0100000_101);
    step();
    check("srai_alu", {29'h0, aluctrl}, 32'h7);
    check("srai_data2", data2, 32'd4);
    check("srai_store", store_data, 32'h5);

    for (int i = 0; i < 12; i++) begin
      set_id(32'h1, 32'h2, 32'h0, 5'd1, 5'd2, 5'd9, {5'b10000, tab_op[i]}, tab_fn[i]);
      step();
      check($sformatf("dec%0d_alu", i), {29'h0, aluctrl}, {29'h0, tab_exp[i]});
    end

    // add x5 then add x6, x5, x2 with both forwarding stages matching x5
    set_id(32'h1, 32'h2, 32'h0, 5'd1, 5'd2, 5'd5, C_RTYPE, F_ADD);
    step();
    set_id(32'h11, 32'h22, 32'h0, 5'd5, 5'd2, 5'd6, C_RTYPE, F_ADD);
    step();
    exmem_rw = 1'b1; exmem_rd = 5'd5; exmem_data = 32'h55;
    memwb_rw = 1'b1; memwb_rd = 5'd5; memwb_data = 32'h66;
    #1 check("fwd_exmem_pri", data1, 32'h55);
    check("fwd_rs2_rf", data2, 32'h22);
    exmem_rw = 1'b0;
    #1 check("fwd_memwb", data1, 32'h66);
    memwb_rw = 1'b0;
    #1 check("fwd_none", data1, 32'h11);
    exmem_rw = 1'b1; exmem_rd = 5'd2; exmem_data = 32'hAB;
    #1 check("fwd_rs2_data2", data2, 32'hAB);
    check("fwd_rs2_store", store_data, 32'hAB);
    fwd_off();

    // lw x7, 8(x1) then add x8, x1, x7 -> one-cycle bubble
    set_id(32'h100, 32'h0, 32'd8, 5'd1, 5'd0, 5'd7, C_LOAD, 10'h0);
    step();
    check("lw_ctrl", {28'h0, ctrl_out}, 32'hE);
    set_id(32'h3, 32'h999, 32'h0, 5'd1, 5'd7, 5'd8, C_RTYPE, F_ADD);
    #1 check("lu_hazard", {31'h0, hazard}, 32'h1);
    step();
    check("lu_bub_ctrl", {28'h0, ctrl_out}, 32'h0);
    check("lu_bub_rd", {27'h0, rd_out}, 32'h0);
    check("lu_bub_alu", {29'h0, aluctrl}, 32'h0);
    check("lu_bub_hazard", {31'h0, hazard}, 32'h0);
    step();
    memwb_rw = 1'b1; memwb_rd = 5'd7; memwb_data = 32'h77;
    #1 check("lu_fwd_data2", data2, 32'h77);
    check("lu_rd", {27'h0, rd_out}, 32'd8);
    check("lu_data1", data1, 32'h3);
    fwd_off();

    // load-use hazard under stall: hold wins, bubble after release
    set_id(32'h100, 32'h0, 32'd8, 5'd1, 5'd0, 5'd7, C_LOAD, 10'h0);
    step();
    set_id(32'h3, 32'h4, 32'h0, 5'd7, 5'd2, 5'd8, C_RTYPE, F_ADD);
    stall = 1'b1;
    step();
    check("sh_hazard", {31'h0, hazard}, 32'h1);
    check("sh_ctrl_hold", {28'h0, ctrl_out}, 32'hE);
    check("sh_data2_hold", data2, 32'd8);
    stall = 1'b0;
    step();
    check("sh_bub_ctrl", {28'h0, ctrl_out}, 32'h0);
    check("sh_bub_rd", {27'h0, rd_out}, 32'h0);
    step();
    memwb_rw = 1'b1; memwb_rd = 5'd7; memwb_data = 32'h70;
    #1 check("sh_fwd_data1", data1, 32'h70);
    fwd_off();

    // x0 is never forwarded
    set_id(32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd10, C_RTYPE, F_ADD);
    step();
    exmem_rw = 1'b1; exmem_rd = 5'd0; exmem_data = 32'hDEAD;
    memwb_rw = 1'b1; memwb_rd = 5'd0; memwb_data = 32'hBEEF;
    #1 check("x0_data1", data1, 32'h0);
    check("x0_store", store_data, 32'h0);
    fwd_off();

    // stall holds register across 3 cycles while ID changes
    set_id(32'd10, 32'd3, 32'h0, 5'd1, 5'd2, 5'd3, C_RTYPE, F_SUB);
    step();
    stall = 1'b1;
    set_id(32'd99, 32'd98, 32'h0, 5'd4, 5'd5, 5'd6, C_RTYPE, F_ADD);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("stall%0d_alu", i), {29'h0, aluctrl}, 32'h4);
      check($sformatf("stall%0d_data1", i), data1, 32'd10);
    end
    stall = 1'b0;

    // flush inserts a bubble
    set_id(32'd10, 32'd3, 32'h0, 5'd1, 5'd2, 5'd3, C_RTYPE, F_SUB);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_ctrl", {28'h0, ctrl_out}, 32'h0);
    check("flush_rd", {27'h0, rd_out}, 32'h0);
    check("flush_alu", {29'h0, aluctrl}, 32'h0);
    check("flush_data1", data1, 32'h0);

    // reset mid-stream
    step();
    check("pre_rst_alu", {29'h0, aluctrl}, 32'h4);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_all_zero("midrst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
